// File: rtl/cv32e40p_mult_tmr_ctrl.sv
// Replay/fatal controller for a triple-redundant multiplier: flushes and re-issues
// an operation whenever the voter flags disagreement, escalating to a latched error.
module cv32e40p_mult_tmr_ctrl #(
    parameter int unsigned MAX_RETRY = 2,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 op_en_i,
    input  logic                 mult_ready_i,
    input  logic                 faulty_i,
    input  logic                 clear_i,
    input  logic                 cnt_clr_i,
    output logic                 mult_en_o,
    output logic                 ready_o,
    output logic                 replay_o,
    output logic                 fatal_o,
    output logic [2:0]           retry_cnt_o,
    output logic [CNT_WIDTH-1:0] fault_cnt_o
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        ERROR = 2'd2
    } state_t;

    localparam logic [2:0]           MAX_RETRY_C = 3'(MAX_RETRY);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX_C   = {CNT_WIDTH{1'b1}};

    state_t               state_r;
    state_t               state_nxt_s;
    logic [2:0]           retry_cnt_r;
    logic [2:0]           retry_nxt_s;
    logic [CNT_WIDTH-1:0] fault_cnt_r;
    logic                 fault_inc_s;

    // Next-state, retry bookkeeping and the two combinational handshake outputs.
    always_comb begin
        state_nxt_s = state_r;
        retry_nxt_s = retry_cnt_r;
        fault_inc_s = 1'b0;
        mult_en_o   = 1'b0;
        ready_o     = 1'b0;
        case (state_r)
            RUN: begin
                mult_en_o = op_en_i;
                ready_o   = op_en_i & mult_ready_i & ~faulty_i;
                if (!op_en_i) begin
                    retry_nxt_s = 3'd0;
                end else if (mult_ready_i) begin
                    // Only a voted completion is judged; faulty_i alone is noise.
                    if (faulty_i) begin
                        fault_inc_s = 1'b1;
                        if (retry_cnt_r < MAX_RETRY_C) begin
                            state_nxt_s = FLUSH;
                            retry_nxt_s = retry_cnt_r + 3'd1;
                        end else begin
                            state_nxt_s = ERROR;
                        end
                    end else begin
                        retry_nxt_s = 3'd0;
                    end
                end else begin
                    retry_nxt_s = retry_cnt_r;
                end
            end
            FLUSH: begin
                state_nxt_s = RUN;
            end
            ERROR: begin
                if (clear_i) begin
                    state_nxt_s = RUN;
                    retry_nxt_s = 3'd0;
                end else begin
                    state_nxt_s = ERROR;
                end
            end
            default: begin
                state_nxt_s = RUN;
                retry_nxt_s = 3'd0;
            end
        endcase
    end

    // State and retry counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= RUN;
            retry_cnt_r <= 3'd0;
        end else begin
            state_r     <= state_nxt_s;
            retry_cnt_r <= retry_nxt_s;
        end
    end

    // Saturating fault counter; a clear always beats a coincident increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_cnt_r <= '0;
        end else if (cnt_clr_i) begin
            fault_cnt_r <= '0;
        end else if (fault_inc_s && (fault_cnt_r != CNT_MAX_C)) begin
            fault_cnt_r <= fault_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            fault_cnt_r <= fault_cnt_r;
        end
    end

    // Decoded from state so reset removes them immediately.
    assign replay_o    = (state_r == FLUSH);
    assign fatal_o     = (state_r == ERROR);
    assign retry_cnt_o = retry_cnt_r;
    assign fault_cnt_o = fault_cnt_r;

endmodule

// File: tb/tb_cv32e40p_mult_tmr_ctrl.sv
// Directed self-checking bench for cv32e40p_mult_tmr_ctrl (MAX_RETRY=2, CNT_WIDTH=2).
module tb_cv32e40p_mult_tmr_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       op_en_i, mult_ready_i, faulty_i, clear_i, cnt_clr_i;
    logic       mult_en_o, ready_o, replay_o, fatal_o;
    logic [2:0] retry_cnt_o;
    logic [1:0] fault_cnt_o;

    int total = 0;
    int bad   = 0;

    cv32e40p_mult_tmr_ctrl #(.MAX_RETRY(2), .CNT_WIDTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .op_en_i      (op_en_i),
        .mult_ready_i (mult_ready_i),
        .faulty_i     (faulty_i),
        .clear_i      (clear_i),
        .cnt_clr_i    (cnt_clr_i),
        .mult_en_o    (mult_en_o),
        .ready_o      (ready_o),
        .replay_o     (replay_o),
        .fatal_o      (fatal_o),
        .retry_cnt_o  (retry_cnt_o),
        .fault_cnt_o  (fault_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic op, input logic rdy, input logic flt,
                         input logic clr, input logic cclr);
        op_en_i = op; mult_ready_i = rdy; faulty_i = flt; clear_i = clr; cnt_clr_i = cclr;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flags(input string tag, input logic en, input logic rdy,
                             input logic rep, input logic fat);
        chk({tag, ".mult_en"}, 32'(mult_en_o), 32'(en));
        chk({tag, ".ready"},   32'(ready_o),   32'(rdy));
        chk({tag, ".replay"},  32'(replay_o),  32'(rep));
        chk({tag, ".fatal"},   32'(fatal_o),   32'(fat));
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.retry", 32'(retry_cnt_o), 32'd0);
        chk("reset.fault", 32'(fault_cnt_o), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Clean completion: ready in the same cycle, nothing counted
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_flags("clean", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_flags("clean.after", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("clean.retry", 32'(retry_cnt_o), 32'd0);
        chk("clean.fault", 32'(fault_cnt_o), 32'd0);

        // faulty_i without ready is ignored
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_flags("noready", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_flags("noready.next", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("noready.fault", 32'(fault_cnt_o), 32'd0);

        // Single transient fault
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk_flags("trans.c0", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_flags("trans.flush", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("trans.retry1", 32'(retry_cnt_o), 32'd1);
        chk("trans.fault1", 32'(fault_cnt_o), 32'd1);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_flags("trans.redo", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("trans.retry0", 32'(retry_cnt_o), 32'd0);
        chk("trans.fault", 32'(fault_cnt_o), 32'd1);
        chk("trans.replay", 32'(replay_o), 32'd0);

        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("cclr.fault", 32'(fault_cnt_o), 32'd0);

        // Persistent fault: two replays, then ERROR
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_flags("pers.f1", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("pers.r1", 32'(retry_cnt_o), 32'd1);
        tick();
        chk_flags("pers.run2", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_flags("pers.f2", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("pers.r2", 32'(retry_cnt_o), 32'd2);
        tick();
        chk_flags("pers.run3", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_flags("pers.err", 1'b0, 1'b0, 1'b0, 1'b1);
        chk("pers.fault3", 32'(fault_cnt_o), 32'd3);
        chk("pers.rkeep", 32'(retry_cnt_o), 32'd2);
        tick();
        chk_flags("pers.hold", 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_flags("pers.clr", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pers.clr.retry", 32'(retry_cnt_o), 32'd0);

        // Saturation at 3, then kill mid-operation
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sat.fault", 32'(fault_cnt_o), 32'd3);
        chk("kill.r1", 32'(retry_cnt_o), 32'd1);
        tick();
        tick();
        chk("kill.r0", 32'(retry_cnt_o), 32'd0);
        chk("kill.fatal", 32'(fatal_o), 32'd0);

        // Counter clear wins over a coincident fault
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("cclrwin.fault", 32'(fault_cnt_o), 32'd0);
        chk("cclrwin.replay", 32'(replay_o), 32'd1);
        tick();
        tick();
        chk("cclr.inc", 32'(fault_cnt_o), 32'd1);

        // Reset while in FLUSH
        chk("rstf.pre", 32'(replay_o), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk_flags("rstf.async", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rstf.fault", 32'(fault_cnt_o), 32'd0);
        rst = 1'b0;
        tick();
        chk_flags("rstf.after", 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset while in ERROR
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        chk("rste.pre", 32'(fatal_o), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk_flags("rste.async", 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk_flags("rste.after", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rste.fault", 32'(fault_cnt_o), 32'd0);
        chk("rste.retry", 32'(retry_cnt_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cv32e40p_mult_tmr_ctrl.md
CV32E40P_MULT_TMR_CTRL -- requirements
Module: cv32e40p_mult_tmr_ctrl

Interface
REQ-001 Parameter MAX_RETRY, default 2, meaning the number of replays allowed per operation before a fatal error (range 1..7).
REQ-002 Parameter CNT_WIDTH, default 16, meaning the width of the saturating fault counter.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 op_en_i  input  1  EX stage holds a multiply operation (level, held until ready_o).
REQ-006 mult_ready_i  input  1  voted ready from the TMR multiplier voter.
REQ-007 faulty_i  input  1  voter disagreement flag, valid in the same cycle as mult_ready_i.
REQ-008 clear_i  input  1  software/debug acknowledge releasing the ERROR state.
REQ-009 cnt_clr_i  input  1  synchronous clear of the fault counter.
REQ-010 mult_en_o  output  1  enable driven to all three multiplier replicas.
REQ-011 ready_o  output  1  gated ready returned to EX.
REQ-012 replay_o  output  1  one-cycle pulse: replicas flushed, operation re-issued.
REQ-013 fatal_o  output  1  persistent fault; the multiplier is unusable.
REQ-014 retry_cnt_o  output  3  replays consumed by the current operation.
REQ-015 fault_cnt_o  output  CNT_WIDTH  total faulty completions since reset or clear.

Function
REQ-016 The FSM SHALL have exactly three states: RUN, FLUSH and ERROR.
REQ-017 RUN: mult_en_o = op_en_i; ready_o = op_en_i & mult_ready_i & ~faulty_i; replay_o = 0; fatal_o = 0.
REQ-018 RUN, completion with fault (op_en_i & mult_ready_i & faulty_i) and retry_cnt < MAX_RETRY: go to FLUSH next cycle, retry_cnt +1, fault_cnt +1.
REQ-019 RUN, completion with fault and retry_cnt == MAX_RETRY: go to ERROR next cycle, fault_cnt +1, retry_cnt unchanged.
REQ-020 RUN, clean completion (op_en_i & mult_ready_i & ~faulty_i): retry_cnt cleared to 0 next cycle; stay in RUN.
REQ-021 RUN with op_en_i = 0 (operation killed or absent): retry_cnt cleared to 0.
REQ-022 faulty_i while mult_ready_i = 0 SHALL be ignored; only voted completions are judged.
REQ-023 FLUSH: mult_en_o = 0, ready_o = 0, replay_o = 1; lasts exactly one cycle, then return to RUN unconditionally; the replicas' multicycle/mulh state is thereby reset.
REQ-024 Each faulty attempt SHALL therefore cost exactly 1 flush cycle plus the multiplier latency before re-completion.
REQ-025 ERROR: mult_en_o = 0, ready_o = 0, fatal_o = 1; the FSM remains in ERROR until clear_i = 1, then goes to RUN with retry_cnt = 0.
REQ-026 clear_i SHALL be ignored in RUN and FLUSH.
REQ-027 fault_cnt SHALL saturate at 2^CNT_WIDTH-1 and never wrap.
REQ-028 cnt_clr_i SHALL set fault_cnt to 0 in any state; when it coincides with an increment, the clear wins and the increment is dropped.
REQ-029 ready_o and replay_o SHALL never be high in the same cycle, and ready_o SHALL never be high while faulty_i = 1.
REQ-030 All outputs except ready_o and mult_en_o (combinational from the inputs and state) SHALL be registered or decoded from state only.

Reset
REQ-031 On rst = 1 (asynchronous): state = RUN, retry_cnt = 0, fault_cnt = 0, replay_o = 0, fatal_o = 0; mult_en_o and ready_o follow REQ-017 with state RUN.
REQ-032 Reset asserted in FLUSH or ERROR SHALL abort that state immediately; no replay pulse or fatal level SHALL persist after reset is released.

Verification
REQ-033 Clean op: op_en_i = 1, mult_ready_i = 1, faulty_i = 0 in cycle 0 -> ready_o = 1 in cycle 0, replay_o never asserts, fault_cnt_o = 0.
REQ-034 Single transient: first completion faulty, second clean -> replay_o high exactly 1 cycle, mult_en_o low that cycle, ready_o high on the second completion, fault_cnt_o = 1, retry_cnt_o returns to 0.
REQ-035 Persistent fault with MAX_RETRY = 2: three faulty completions -> two replay pulses, then fatal_o = 1, fault_cnt_o = 3, ready_o stays 0; clear_i = 1 -> RUN, retry_cnt_o = 0.
REQ-036 Saturation with CNT_WIDTH = 2: five faulty completions separated by clears of ERROR -> fault_cnt_o holds at 3; cnt_clr_i coincident with a fault -> fault_cnt_o = 0.
REQ-037 Kill mid-operation: one faulty completion (retry_cnt_o = 1), then op_en_i dropped for 1 cycle -> retry_cnt_o = 0, no ERROR entry.
REQ-038 Reset in ERROR and in FLUSH -> fatal_o and replay_o drop asynchronously, state = RUN after release, fault_cnt_o = 0.
